game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL provide port: clock  input  1  rising-edge system clock.
REQ-002 SHALL provide port: reset  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide port: start  input  1  one-cycle request to begin a game; ignored unless IDLE.
REQ-004 SHALL provide port: card_valid  input  1  card source has a card on card_value.
REQ-005 SHALL provide port: card_value  input  4  card rank value; ace=1, face cards=10.
REQ-006 SHALL provide port: stand_btn  input  1  punter stand request (level, pre-synchronised).
REQ-007 SHALL provide port: card_req  output  1  card request to card source.
REQ-008 SHALL provide port: game_on  output  1  game in progress; feeds winner logic.
REQ-009 SHALL provide port: total_value  output  5  effective total of current hand.
REQ-010 SHALL provide port: hold  output  1  one-cycle pulse: current hand stands.
REQ-011 SHALL provide port: bust  output  1  one-cycle pulse: current hand exceeds 21.
REQ-012 SHALL provide port: turn  output  1  0=dealer hand, 1=punter hand.
REQ-013 SHALL provide port: game_done  output  1  one-cycle pulse when both hands have finished.
REQ-014 SHALL provide parameter: DEALER_STAND, default 17, dealer auto-stand threshold.

Function
REQ-015 SHALL implement states IDLE, DEAL, EVAL, STAND, BUST, SWITCH, FINISH.
REQ-016 IDLE: start=1 -> DEAL, game_on=1, turn=0, hand cleared; start in any other state ignored.
REQ-017 DEAL: card_req=1; card accepted only on cycle with card_req=1 and card_valid=1; then -> EVAL next cycle.
REQ-018 card_value=0 SHALL be ignored (no accept, card_req stays high); values 11-15 SHALL be treated as 10.
REQ-019 hard total SHALL accumulate in 5 bits; max reachable 30 (20 + 10), no wrap; ace flag set when any ace accepted.
REQ-020 effective total = hard+10 if ace flag and hard<=11, else hard; total_value SHALL show effective total, updated the cycle after accept.
REQ-021 EVAL with fewer than 2 cards in hand -> DEAL.
REQ-022 EVAL: hard>21 -> BUST; else dealer with effective>=DEAL_STAND -> STAND; else punter with effective=21 -> STAND; else punter with stand_btn=1 -> STAND; else -> DEAL.
REQ-023 punter stand_btn SHALL only be sampled in EVAL; stand_btn during DEAL is not acted on until EVAL.
REQ-024 STAND asserts hold=1 for exactly one cycle; BUST asserts bust=1 for exactly one cycle; hold and bust SHALL never be high together.
REQ-025 total_value SHALL remain stable during the hold/bust cycle and the following cycle.
REQ-026 After STAND/BUST with turn=0 -> SWITCH: clear hand, turn=1, -> DEAL; punter plays even if dealer busted.
REQ-027 After STAND/BUST with turn=1 -> FINISH: game_done=1 one cycle, game_on=0 from next cycle, -> IDLE.
REQ-028 game_on SHALL be 1 in every state except IDLE, including the hold/bust cycle.
REQ-029 card_req SHALL be 1 only in DEAL.
REQ-030 turn SHALL change only in SWITCH and IDLE entry; total_value holds final punter total in IDLE until next start.

Reset
REQ-031 reset=0 sampled on clock edge SHALL force IDLE, game_on=0, card_req=0, hold=0, bust=0, game_done=0, turn=0, total_value=0, ace flag=0, card count=0.
REQ-032 reset mid-game SHALL abandon the game with no hold/bust/game_done pulse; reset SHALL dominate start.

Structure
REQ-033 shared package SHALL hold state encoding, DEALER/PUNTER turn constants, BLACKJACK=21, ACE_BONUS=10.
REQ-034 hand accumulation (hard total, ace flag, card count, effective total) SHALL be one sub-module hand_accum; FSM stays in game_sequencer.

Verification
REQ-035 dealer 10,7 then punter 10,9 with stand_btn -> dealer hold pulse total 17, punter hold pulse total 19, game_done, game_on falls.
REQ-036 dealer 10,6,10 -> bust pulse with hard 26, turn -> 1; punter 1,10 -> hold at effective 21 without stand_btn.
REQ-037 dealer 1,6 -> hold at effective 17 (soft); punter 1,1,10 -> total 12, no bust.
REQ-038 card_valid held low 20 cycles in DEAL -> card_req stays high, state and totals unchanged; card_value=0 never accepted.
REQ-039 reset low during punter DEAL -> IDLE next edge, all outputs zero, no pulses; start next cycle begins new game with turn=0.
REQ-040 start asserted during game and stand_btn held in DEAL -> no effect until punter EVAL.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared state encoding, turn constants and card helpers
package game_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, DEAL, EVAL, STAND, BUST, SWITCH, FINISH} state_t;
  localparam logic DEALER = 1'b0;
  localparam logic PUNTER = 1'b1;
  localparam logic [4:0] BLACKJACK = 5'd21;
  localparam logic [4:0] ACE_BONUS = 5'd10;
  function automatic logic [4:0] card_rank(input logic [3:0] v);
    return (v > 4'd10) ? 5'd10 : {1'b0, v};
  endfunction
endpackage

// File: rtl/game_sequencer_hand_accum.sv
// hand_accum: hard total, ace flag, saturating card count and effective total of one hand
module hand_accum
  import game_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       accept_i,
  input  logic [3:0] value_i,
  output logic [4:0] hard_o,
  output logic [4:0] eff_o,
  output logic [1:0] count_o
);
  logic [4:0] hard_q, hard_d;
  logic       ace_q, ace_d;
  logic [1:0] count_q, count_d;
  // next hand state: clear wins, otherwise add the clamped rank of an accepted card
  always_comb begin
    hard_d  = clear_i ? 5'd0 : accept_i ? hard_q + card_rank(value_i) : hard_q;
    ace_d   = clear_i ? 1'b0 : ace_q | (accept_i && value_i == 4'd1);
    count_d = clear_i ? 2'd0 : (accept_i && count_q != 2'd2) ? count_q + 2'd1 : count_q;
  end
  // hand registers, cleared by the active-low synchronous reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      hard_q  <= 5'd0;
      ace_q   <= 1'b0;
      count_q <= 2'd0;
    end else begin
      hard_q  <= hard_d;
      ace_q   <= ace_d;
      count_q <= count_d;
    end
  end
  assign hard_o  = hard_q;
  assign count_o = count_q;
  assign eff_o   = (ace_q && hard_q <= BLACKJACK - ACE_BONUS) ? hard_q + ACE_BONUS : hard_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: dealer-then-punter blackjack hand sequencer with registered outputs
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int DEALER_STAND = 17
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  input  logic       stand_btn,
  output logic       card_req,
  output logic       game_on,
  output logic [4:0] total_value,
  output logic       hold,
  output logic       bust,
  output logic       turn,
  output logic       game_done
);
  state_t     state_q;
  logic       card_req_q, game_on_q, hold_q, bust_q, done_q, turn_q;
  logic       accept, clear, stands;
  logic [4:0] hard, eff;
  logic [1:0] count;
  assign accept = card_req_q && card_valid && card_value != 4'd0;
  assign clear  = (state_q == IDLE && start) || state_q == SWITCH;
  assign stands = (turn_q == DEALER) ? (eff >= 5'(DEALER_STAND))
                                     : (eff == BLACKJACK || stand_btn);
  hand_accum u_hand (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (clear),
    .accept_i (accept),
    .value_i  (card_value),
    .hard_o   (hard),
    .eff_o    (eff),
    .count_o  (count)
  );
  // game FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      card_req_q <= 1'b0;
      game_on_q  <= 1'b0;
      hold_q     <= 1'b0;
      bust_q     <= 1'b0;
      done_q     <= 1'b0;
      turn_q     <= DEALER;
    end else begin
      hold_q <= 1'b0;
      bust_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= DEAL;
          game_on_q  <= 1'b1;
          turn_q     <= DEALER;
          card_req_q <= 1'b1;
        end
        DEAL: if (accept) begin
          state_q    <= EVAL;
          card_req_q <= 1'b0;
        end
        EVAL: if (count < 2'd2) begin
          state_q    <= DEAL;
          card_req_q <= 1'b1;
        end else if (hard > BLACKJACK) begin
          state_q <= BUST;
          bust_q  <= 1'b1;
        end else if (stands) begin
          state_q <= STAND;
          hold_q  <= 1'b1;
        end else begin
          state_q    <= DEAL;
          card_req_q <= 1'b1;
        end
        STAND, BUST: begin
          state_q <= (turn_q == PUNTER) ? FINISH : SWITCH;
          done_q  <= turn_q == PUNTER;
        end
        SWITCH: begin
          state_q    <= DEAL;
          turn_q     <= PUNTER;
          card_req_q <= 1'b1;
        end
        FINISH: begin
          state_q   <= IDLE;
          game_on_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign card_req    = card_req_q;
  assign game_on     = game_on_q;
  assign hold        = hold_q;
  assign bust        = bust_q;
  assign game_done   = done_q;
  assign turn        = turn_q;
  assign total_value = eff;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized blackjack games scored against a hand-value model
module tb_game_sequencer;
  logic       clock = 0, reset = 0, start = 0, card_valid = 0, stand_btn = 0;
  logic [3:0] card_value = 0;
  logic       card_req, game_on, hold, bust, turn, game_done;
  logic [4:0] total_value;
  typedef struct packed {logic b; logic [4:0] t; logic tr;} exp_t;
  exp_t       eq[$];
  logic [3:0] dcards[$], pcards[$];
  bit         psb[$];
  int         checks = 0, failures = 0, done_exp = 0, stall_force = -1;
  bit         prev_hb = 0, prev_done = 0;
  logic [4:0] prev_tot = 0, last_ptot = 0;

  always #5 clock = ~clock;

  game_sequencer #(.DEALER_STAND(17)) dut (
    .clock(clock), .reset(reset), .start(start), .card_valid(card_valid),
    .card_value(card_value), .stand_btn(stand_btn), .card_req(card_req),
    .game_on(game_on), .total_value(total_value), .hold(hold), .bust(bust),
    .turn(turn), .game_done(game_done)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  function automatic int hand_value(input int hard, input bit ace);
    return (ace && hard + 10 <= 21) ? hard + 10 : hard;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (prev_hb) chk("total_after_pulse", total_value, prev_tot);
    if (prev_done) begin
      chk("game_on_after_done", game_on, 0);
      chk("total_in_idle", total_value, last_ptot);
    end
    prev_hb = 0;
    prev_done = 0;
    if (hold || bust) begin
      chk("hold_bust_exclusive", hold & bust, 0);
      chk("game_on_in_pulse", game_on, 1);
      chk("card_req_in_pulse", card_req, 0);
      chk("pulse_expected", eq.size() != 0, 1);
      if (eq.size() != 0) begin
        e = eq.pop_front();
        chk("pulse_is_bust", bust, e.b);
        chk("pulse_total", total_value, e.t);
        chk("pulse_turn", turn, e.tr);
        if (e.tr) last_ptot = e.t;
      end
      prev_hb = 1;
      prev_tot = total_value;
    end
    if (game_done) begin
      chk("done_expected", done_exp > 0, 1);
      if (done_exp > 0) done_exp--;
      chk("done_turn", turn, 1);
      chk("done_game_on", game_on, 1);
      prev_done = 1;
    end
  end

  task automatic deal_card(input logic [3:0] v, input bit sb, input int cur, input int nx);
    int k = 0, stall;
    @(negedge clock);
    while (!card_req && k < 60) begin
      @(negedge clock);
      k++;
    end
    chk("card_req_seen", card_req, 1);
    stand_btn = sb;
    stall = stall_force >= 0 ? stall_force : $urandom_range(0, 3);
    for (int i = 0; i < stall; i++) begin
      card_valid = 1'($urandom_range(0, 1));
      card_value = 4'd0;
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("stall_card_req", card_req, 1);
      chk("stall_total", total_value, cur);
    end
    start = 0;
    card_valid = 1;
    card_value = v;
    @(negedge clock);
    card_valid = 0;
    card_value = 4'($urandom);
    chk("total_after_accept", total_value, nx);
  endtask

  task automatic play_game(input bit do_start);
    int hard, n, cur, nx, r, k;
    bit ace, sb, fin;
    logic [3:0] v;
    if (do_start) begin
      @(negedge clock);
      start = 1;
      @(negedge clock);
      start = 0;
      chk("game_on_at_start", game_on, 1);
      chk("turn_at_start", turn, 0);
    end
    for (int t = 0; t < 2; t++) begin
      hard = 0; ace = 0; n = 0; fin = 0;
      while (!fin) begin
        if (t == 0) v = dcards.size() != 0 ? dcards.pop_front() : 4'($urandom_range(1, 15));
        else        v = pcards.size() != 0 ? pcards.pop_front() : 4'($urandom_range(1, 15));
        if (t == 0) sb = 1'($urandom_range(0, 1));
        else        sb = psb.size() != 0 ? psb.pop_front() : ($urandom_range(0, 3) == 0);
        cur = hand_value(hard, ace);
        r = v > 10 ? 10 : int'(v);
        hard += r;
        ace |= (r == 1);
        n++;
        nx = hand_value(hard, ace);
        deal_card(v, sb, cur, nx);
        if (n >= 2) begin
          if (hard > 21) begin
            eq.push_back('{b: 1'b1, t: 5'(hard), tr: t[0]});
            fin = 1;
          end else if (t == 0 ? nx >= 17 : (nx == 21 || sb)) begin
            eq.push_back('{b: 1'b0, t: 5'(nx), tr: t[0]});
            fin = 1;
          end
        end
      end
    end
    done_exp++;
    k = 0;
    while (!game_done && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("game_done_seen", game_done, 1);
    stand_btn = 0;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_game_on", game_on, 0);
    chk("rst_card_req", card_req, 0);
    chk("rst_total", total_value, 0);
    chk("rst_turn", turn, 0);
    chk("rst_pulses", {hold, bust, game_done}, 0);
    reset = 1;
    dcards = '{10, 7}; pcards = '{10, 9}; psb = '{0, 1};
    play_game(1);
    dcards = '{10, 6, 10}; pcards = '{1, 10}; psb = '{0, 0};
    play_game(1);
    dcards = '{1, 6}; pcards = '{1, 1, 10}; psb = '{0, 0, 1};
    play_game(1);
    stall_force = 20;
    play_game(1);
    stall_force = -1;
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    deal_card(10, 0, 0, 10);
    deal_card(7, 0, 10, 17);
    eq.push_back('{b: 1'b0, t: 5'd17, tr: 1'b0});
    deal_card(5, 1, 0, 5);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    reset = 1;
    stand_btn = 0;
    chk("midrst_game_on", game_on, 0);
    chk("midrst_card_req", card_req, 0);
    chk("midrst_total", total_value, 0);
    chk("midrst_turn", turn, 0);
    chk("midrst_pulses", {hold, bust, game_done}, 0);
    start = 1;
    @(negedge clock);
    start = 0;
    chk("restart_game_on", game_on, 1);
    chk("restart_turn", turn, 0);
    chk("restart_card_req", card_req, 1);
    play_game(0);
    for (int g = 0; g < 40; g++) play_game(1);
    repeat (3) @(negedge clock);
    chk("pulses_drained", eq.size(), 0);
    chk("done_drained", done_exp, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
